// File: rtl/conv_a1_ctrl_pkg.sv
// Shared sizes, derived widths and state encoding for the ConvA1 controller.
// Later conv controllers import the same package with their own values.
// Typed terminal constants keep every counter compare width-exact.
package conv_a1_ctrl_pkg;

  localparam int IFM_SIZE          = 32;
  localparam int KERNAL_SIZE       = 5;
  localparam int NUMBER_OF_FILTERS = 6;
  localparam int PIPE_LATENCY      = 3;

  localparam int IFM_SIZE_NEXT = IFM_SIZE - KERNAL_SIZE + 1;
  localparam int KERNAL_AREA   = KERNAL_SIZE * KERNAL_SIZE;
  localparam int IFM_AREA      = IFM_SIZE * IFM_SIZE;
  localparam int NEXT_AREA     = IFM_SIZE_NEXT * IFM_SIZE_NEXT;

  localparam int ADDRESS_SIZE_IFM      = $clog2(IFM_AREA);
  localparam int ADDRESS_SIZE_NEXT_IFM = $clog2(NEXT_AREA);
  localparam int ADDRESS_SIZE_WM       = $clog2(KERNAL_AREA * NUMBER_OF_FILTERS);
  localparam int ADDRESS_SIZE_BM       = $clog2(NUMBER_OF_FILTERS);
  localparam int COORD_W               = $clog2(IFM_SIZE);
  localparam int K_W                   = $clog2(KERNAL_AREA);
  // One extra bit so the write counter can be compared against the full map size.
  localparam int WCNT_W                = ADDRESS_SIZE_NEXT_IFM + 1;

  localparam logic [K_W-1:0]              K_LAST     = K_W'(KERNAL_AREA - 1);
  localparam logic [ADDRESS_SIZE_IFM-1:0] P_LAST     = ADDRESS_SIZE_IFM'(IFM_AREA - 1);
  localparam logic [COORD_W-1:0]          COORD_LAST = COORD_W'(IFM_SIZE - 1);
  localparam logic [COORD_W-1:0]          COORD_MIN  = COORD_W'(KERNAL_SIZE - 1);
  localparam logic [ADDRESS_SIZE_BM-1:0]  F_LAST     = ADDRESS_SIZE_BM'(NUMBER_OF_FILTERS - 1);
  localparam logic [ADDRESS_SIZE_WM-1:0]  WBASE_STEP = ADDRESS_SIZE_WM'(KERNAL_AREA);
  localparam logic [WCNT_W-1:0]           WCNT_FULL  = WCNT_W'(NEXT_AREA);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_B = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/conv_a1_ctrl_delay_line.sv
// Reset-cleared shift register used to align control with registered memory reads and the datapath.
// Latency: DEPTH cycles from d to q.
// No backpressure: shifts every cycle.
module conv_a1_ctrl_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per cycle; reset empties the whole line so no stale pulse escapes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/conv_a1_ctrl.sv
// Sequencer for ConvA1: per filter loads kernel, selects bias, streams IFM, writes results, then pulses done.
// Latency per filter: 25 load + 1 bias + 1024 stream + PIPE_LATENCY+1 drain cycles.
// No backpressure: memories and datapath accept one item per cycle; start is ignored while busy.
module conv_a1_ctrl
  import conv_a1_ctrl_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
  output logic                             ifm_enable_read_current,
  output logic                             fifo_enable,
  output logic                             conv_enable,
  output logic                             wm_addr_sel,
  output logic                             wm_enable_read,
  output logic [ADDRESS_SIZE_WM-1:0]       wm_address_read_current,
  output logic                             wm_fifo_enable,
  output logic                             bm_addr_sel,
  output logic                             bm_enable_read,
  output logic [ADDRESS_SIZE_BM-1:0]       bm_address_read_current,
  output logic [NUMBER_OF_FILTERS-1:0]     ofm_enable_write,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_address
);

  state_t                           state, state_nxt;
  logic [K_W-1:0]                   k;
  logic [COORD_W-1:0]               row, col, row_d, col_d;
  logic [ADDRESS_SIZE_IFM-1:0]      p;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] wcnt;
  logic [WCNT_W-1:0]                wcnt_inc;
  logic [ADDRESS_SIZE_BM-1:0]       f;
  logic [ADDRESS_SIZE_WM-1:0]       wbase;
  logic                             wr_v;
  logic                             last_write;

  assign wcnt_inc   = WCNT_W'(wcnt) + WCNT_W'(1);
  assign last_write = wr_v && (wcnt_inc == WCNT_FULL);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-state memory strobes.
  always_comb begin
    state_nxt               = state;
    busy                    = 1'b0;
    done                    = 1'b0;
    wm_enable_read          = 1'b0;
    bm_enable_read          = 1'b0;
    ifm_enable_read_current = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD_W;
      end
      S_LOAD_W: begin
        busy           = 1'b1;
        wm_enable_read = 1'b1;
        if (k == K_LAST) state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        busy           = 1'b1;
        bm_enable_read = 1'b1;
        state_nxt      = S_STREAM;
      end
      S_STREAM: begin
        busy                    = 1'b1;
        ifm_enable_read_current = 1'b1;
        if (p == P_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (last_write) state_nxt = (f == F_LAST) ? S_DONE : S_LOAD_W;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Kernel, pixel and filter counters; wbase steps by one kernel per filter instead of multiplying.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k     <= '0;
      row   <= '0;
      col   <= '0;
      p     <= '0;
      f     <= '0;
      wbase <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k     <= '0;
            f     <= '0;
            wbase <= '0;
          end
        end
        S_LOAD_W: begin
          k <= (k == K_LAST) ? '0 : k + K_W'(1);
          if (k == K_LAST) begin
            row <= '0;
            col <= '0;
            p   <= '0;
          end
        end
        S_STREAM: begin
          p <= p + ADDRESS_SIZE_IFM'(1);
          if (col == COORD_LAST) begin
            col <= '0;
            row <= row + COORD_W'(1);
          end else begin
            col <= col + COORD_W'(1);
          end
        end
        S_DRAIN: begin
          if (last_write && (f != F_LAST)) begin
            f     <= f + ADDRESS_SIZE_BM'(1);
            wbase <= wbase + WBASE_STEP;
          end
        end
        S_DONE: begin
          f     <= '0;
          wbase <= '0;
        end
        default: ;
      endcase
    end
  end

  // Output write counter: advances on each datapath result, rewinds when a map is complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          wcnt <= '0;
    else if (last_write) wcnt <= '0;
    else if (wr_v)       wcnt <= wcnt_inc[ADDRESS_SIZE_NEXT_IFM-1:0];
  end

  // Read data arrives one cycle after its enable; carry the pixel coordinates along with it.
  conv_a1_ctrl_delay_line #(.WIDTH(2 + 2*COORD_W), .DEPTH(1)) u_rd_align (
    .clk   (clk),
    .reset (reset),
    .d     ({ifm_enable_read_current, wm_enable_read, row, col}),
    .q     ({fifo_enable, wm_fifo_enable, row_d, col_d})
  );

  // Only windows whose bottom-right pixel lies at row,col >= K-1 are complete;
  // this also hides whatever the previous filter left in the line FIFO.
  assign conv_enable = fifo_enable && (row_d >= COORD_MIN) && (col_d >= COORD_MIN);

  conv_a1_ctrl_delay_line #(.WIDTH(1), .DEPTH(PIPE_LATENCY)) u_wr_align (
    .clk   (clk),
    .reset (reset),
    .d     (conv_enable),
    .q     (wr_v)
  );

  assign wm_addr_sel              = busy;
  assign bm_addr_sel              = busy;
  assign wm_address_read_current  = wm_enable_read ? (wbase + ADDRESS_SIZE_WM'(k)) : '0;
  assign ifm_address_read_current = ifm_enable_read_current ? p : '0;
  assign bm_address_read_current  = f;
  assign ofm_enable_write         = wr_v ? (NUMBER_OF_FILTERS'(1) << f) : '0;
  assign ofm_address              = wr_v ? wcnt : '0;

endmodule

// File: tb/tb_conv_a1_ctrl.sv
// Bench for conv_a1_ctrl: hand-computed spot vectors plus a cycle-by-cycle reference model.
// Runs: plain run, run aborted by reset mid-stream of filter 2, run with stray start pulses.
// Outputs sampled and inputs driven on the falling edge.
module tb_conv_a1_ctrl;

  localparam int FILTER_CYC = 25 + 1 + 1024 + 3 + 1;
  localparam int RUN_CYC    = 6 * FILTER_CYC;

  localparam int SG_WM_EN = 0, SG_WM_ADDR = 1, SG_WM_FIFO = 2, SG_BM_EN = 3, SG_BM_ADDR = 4,
                 SG_IFM_EN = 5, SG_IFM_ADDR = 6, SG_CONV = 7, SG_OFM_WE = 8, SG_OFM_ADDR = 9,
                 SG_BUSY = 10, SG_DONE = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, ifm_en, fifo_en, conv_en, wm_sel, wm_en, wm_fifo, bm_sel, bm_en;
  logic [9:0] ifm_addr, ofm_addr;
  logic [7:0] wm_addr;
  logic [2:0] bm_addr;
  logic [5:0] ofm_we;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       busy, done, ifm_en;
    logic [9:0] ifm_addr;
    logic       fifo_en, conv_en, wm_sel, wm_en;
    logic [7:0] wm_addr;
    logic       wm_fifo, bm_sel, bm_en;
    logic [2:0] bm_addr;
    logic [5:0] ofm_we;
    logic [9:0] ofm_addr;
  } obs_t;

  typedef struct {
    string name;
    int    t;
    int    sel;
    int    exp;
  } vec_t;

  vec_t tbl[$];

  conv_a1_ctrl dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .busy                     (busy),
    .done                     (done),
    .ifm_address_read_current (ifm_addr),
    .ifm_enable_read_current  (ifm_en),
    .fifo_enable              (fifo_en),
    .conv_enable              (conv_en),
    .wm_addr_sel              (wm_sel),
    .wm_enable_read           (wm_en),
    .wm_address_read_current  (wm_addr),
    .wm_fifo_enable           (wm_fifo),
    .bm_addr_sel              (bm_sel),
    .bm_enable_read           (bm_en),
    .bm_address_read_current  (bm_addr),
    .ofm_enable_write         (ofm_we),
    .ofm_address              (ofm_addr)
  );

  always #5 clk = ~clk;

  // Expected outputs at cycle t after the start edge (t<0: idle; t==RUN_CYC: done pulse).
  function automatic obs_t model(int t);
    obs_t e;
    int   f, u, s;
    e = '{default: '0};
    if (t < 0) return e;
    if (t >= RUN_CYC) begin
      e.done = (t == RUN_CYC);
      return e;
    end
    f = t / FILTER_CYC;
    u = t % FILTER_CYC;
    e.busy    = 1'b1;
    e.wm_sel  = 1'b1;
    e.bm_sel  = 1'b1;
    e.bm_addr = f[2:0];
    if (u < 25) begin
      e.wm_en   = 1'b1;
      e.wm_addr = 8'(25 * f + u);
    end
    e.wm_fifo = (u >= 1) && (u <= 25);
    e.bm_en   = (u == 25);
    if (u >= 26 && u < 1050) begin
      e.ifm_en   = 1'b1;
      e.ifm_addr = 10'(u - 26);
    end
    if (u >= 27 && u <= 1050) begin
      e.fifo_en = 1'b1;
      s = u - 27;
      e.conv_en = (s / 32 >= 4) && (s % 32 >= 4);
    end
    s = u - 30;
    if (s >= 0 && s < 1024 && (s / 32 >= 4) && (s % 32 >= 4)) begin
      e.ofm_we   = 6'(1 << f);
      e.ofm_addr = 10'((s / 32 - 4) * 28 + (s % 32 - 4));
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.busy = busy; a.done = done; a.ifm_en = ifm_en; a.ifm_addr = ifm_addr;
    a.fifo_en = fifo_en; a.conv_en = conv_en; a.wm_sel = wm_sel; a.wm_en = wm_en;
    a.wm_addr = wm_addr; a.wm_fifo = wm_fifo; a.bm_sel = bm_sel; a.bm_en = bm_en;
    a.bm_addr = bm_addr; a.ofm_we = ofm_we; a.ofm_addr = ofm_addr;
    return a;
  endfunction

  // Flatten, ignoring address fields whose enable is expected low.
  function automatic logic [63:0] pack(obs_t o, obs_t m);
    return {17'd0, o.busy, o.done, o.ifm_en, (m.ifm_en ? o.ifm_addr : 10'd0),
            o.fifo_en, o.conv_en, o.wm_sel, o.wm_en, (m.wm_en ? o.wm_addr : 8'd0),
            o.wm_fifo, o.bm_sel, o.bm_en, (m.bm_en ? o.bm_addr : 3'd0),
            o.ofm_we, ((|m.ofm_we) ? o.ofm_addr : 10'd0)};
  endfunction

  function automatic int get_sig(int sel);
    case (sel)
      SG_WM_EN:    return int'(wm_en);
      SG_WM_ADDR:  return int'(wm_addr);
      SG_WM_FIFO:  return int'(wm_fifo);
      SG_BM_EN:    return int'(bm_en);
      SG_BM_ADDR:  return int'(bm_addr);
      SG_IFM_EN:   return int'(ifm_en);
      SG_IFM_ADDR: return int'(ifm_addr);
      SG_CONV:     return int'(conv_en);
      SG_OFM_WE:   return int'(ofm_we);
      SG_OFM_ADDR: return int'(ofm_addr);
      SG_BUSY:     return int'(busy);
      SG_DONE:     return int'(done);
      default:     return -1;
    endcase
  endfunction

  task automatic cmp(string name, int t, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
    end
  endtask

  task automatic check_obs(string name, int t);
    obs_t e;
    e = model(t);
    cmp(name, t, pack(sample(), e), pack(e, e));
  endtask

  // One run: idle gap, start pulse, then RUN_CYC+20 checked cycles (or abort by reset at abort_at).
  task automatic do_run(int gap, bit noisy, bit use_tbl, int abort_at);
    int conv_cnt[6];
    int busy_cnt, done_cnt;
    for (int i = 0; i < 6; i++) conv_cnt[i] = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int g = 0; g <= gap; g++) begin
      @(negedge clk);
      check_obs("idle", -1);
    end
    start = 1'b1;
    for (int t = 0; t < RUN_CYC + 20; t++) begin
      @(negedge clk);
      start = 1'b0;
      check_obs("model", t);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (conv_en && t < RUN_CYC) conv_cnt[t / FILTER_CYC]++;
      if (use_tbl)
        foreach (tbl[i])
          if (tbl[i].t == t) cmp(tbl[i].name, t, 64'(get_sig(tbl[i].sel)), 64'(tbl[i].exp));
      if (t == abort_at) begin
        #2 reset = 1'b0;
        #1 check_obs("rst_async", -1);
        cmp("rst_filter_idx", t, 64'(bm_addr), 64'd0);
        @(negedge clk);
        check_obs("rst_held", -1);
        reset = 1'b1;
        return;
      end
      if (noisy) start = (t == RUN_CYC) || (t < RUN_CYC && $urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    cmp("busy_cycles", 0, 64'(busy_cnt), 64'(RUN_CYC));
    cmp("done_pulses", 0, 64'(done_cnt), 64'd1);
    for (int i = 0; i < 6; i++) cmp("conv_per_filter", i, 64'(conv_cnt[i]), 64'd784);
  endtask

  initial begin
    // Hand-computed spot checks: t counts cycles after the start edge.
    tbl.push_back('{"wm_en_first",    0,    SG_WM_EN,    1});
    tbl.push_back('{"wm_addr_first",  0,    SG_WM_ADDR,  0});
    tbl.push_back('{"wm_fifo_lag0",   0,    SG_WM_FIFO,  0});
    tbl.push_back('{"wm_fifo_lag1",   1,    SG_WM_FIFO,  1});
    tbl.push_back('{"wm_addr_last",   24,   SG_WM_ADDR,  24});
    tbl.push_back('{"wm_en_off",      25,   SG_WM_EN,    0});
    tbl.push_back('{"wm_fifo_tail",   25,   SG_WM_FIFO,  1});
    tbl.push_back('{"wm_fifo_end",    26,   SG_WM_FIFO,  0});
    tbl.push_back('{"bm_en",          25,   SG_BM_EN,    1});
    tbl.push_back('{"bm_addr_f0",     25,   SG_BM_ADDR,  0});
    tbl.push_back('{"ifm_addr_first", 26,   SG_IFM_ADDR, 0});
    tbl.push_back('{"ifm_addr_last",  1049, SG_IFM_ADDR, 1023});
    tbl.push_back('{"ifm_en_off",     1050, SG_IFM_EN,   0});
    tbl.push_back('{"conv_before",    158,  SG_CONV,     0});
    tbl.push_back('{"conv_first",     159,  SG_CONV,     1});
    tbl.push_back('{"conv_r10c3",     350,  SG_CONV,     0});
    tbl.push_back('{"conv_r10c4",     351,  SG_CONV,     1});
    tbl.push_back('{"we_before",      161,  SG_OFM_WE,   0});
    tbl.push_back('{"we_first",       162,  SG_OFM_WE,   1});
    tbl.push_back('{"addr_first",     162,  SG_OFM_ADDR, 0});
    tbl.push_back('{"we_last_f0",     1053, SG_OFM_WE,   1});
    tbl.push_back('{"addr_last_f0",   1053, SG_OFM_ADDR, 783});
    tbl.push_back('{"wm_addr_f5",     5270, SG_WM_ADDR,  125});
    tbl.push_back('{"wm_addr_f5_end", 5294, SG_WM_ADDR,  149});
    tbl.push_back('{"bm_addr_f5",     5295, SG_BM_ADDR,  5});
    tbl.push_back('{"we_f5",          5432, SG_OFM_WE,   32});
    tbl.push_back('{"addr_last_f5",   6323, SG_OFM_ADDR, 783});
    tbl.push_back('{"busy_last",      6323, SG_BUSY,     1});
    tbl.push_back('{"done_pulse",     6324, SG_DONE,     1});
    tbl.push_back('{"busy_at_done",   6324, SG_BUSY,     0});
    tbl.push_back('{"done_after",     6325, SG_DONE,     0});

    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_obs("reset_state", -1);
    reset = 1'b1;

    do_run(2 + $urandom_range(0, 5), 1'b0, 1'b1, -1);
    do_run($urandom_range(0, 7), 1'b1, 1'b0, 2 * FILTER_CYC + 26 + 300 + $urandom_range(0, 400));
    do_run($urandom_range(0, 7), 1'b1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
